// File: rtl/rotate90_engine.sv
// Rotates a W x H image of pixels held in single-port BRAM by 90 degrees (CW or CCW)
// into a destination region of the same BRAM, one pixel per READ/LATCH/WRITE triple.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// READ  | source address on addr_o, read in flight
// LATCH | data_i valid, captured into data_o on exit
// WRITE | destination address on addr_o, wr_o=1 for this cycle
// DONE  | done=1 for one cycle, then back to IDLE
module rotate90_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic [DIM_WIDTH-1:0]  width,
    input  logic [DIM_WIDTH-1:0]  height,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    output logic                  ready,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  wr_o
);

    typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
    localparam logic [DIM_WIDTH-1:0]  D_ONE = 1;

    state_t                state;
    logic [DIM_WIDTH-1:0]  cfg_width;
    logic [DIM_WIDTH-1:0]  col_left;
    logic [DIM_WIDTH-1:0]  row_left;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_row;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [ADDR_WIDTH-1:0] col_step;
    logic [ADDR_WIDTH-1:0] row_step;

    logic [ADDR_WIDTH-1:0] width_ext;
    logic [ADDR_WIDTH-1:0] height_ext;
    logic [ADDR_WIDTH-1:0] w_m1;
    logic [ADDR_WIDTH-1:0] ccw_off;
    logic [ADDR_WIDTH-1:0] first_dst;

    assign width_ext  = {{(ADDR_WIDTH-DIM_WIDTH){1'b0}}, width};
    assign height_ext = {{(ADDR_WIDTH-DIM_WIDTH){1'b0}}, height};
    assign w_m1       = width_ext - A_ONE;

    // CCW starts at dst_base + (W-1)*H; built once at start as a shift-add of the
    // live geometry inputs, every per-pixel step afterwards is a single add.
    always_comb begin
        ccw_off = '0;
        for (int i = 0; i < DIM_WIDTH; i++) begin
            if (height[i]) begin
                ccw_off = ccw_off + (w_m1 << i);
            end
        end
    end

    assign first_dst = dir ? (dst_base + ccw_off) : (dst_base + height_ext - A_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            addr_o    <= '0;
            data_o    <= '0;
            wr_o      <= 1'b0;
            cfg_width <= '0;
            col_left  <= '0;
            row_left  <= '0;
            src_ptr   <= '0;
            dst_row   <= '0;
            dst_ptr   <= '0;
            col_step  <= '0;
            row_step  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_width <= width;
                        col_left  <= width - D_ONE;
                        row_left  <= height - D_ONE;
                        src_ptr   <= src_base;
                        col_step  <= dir ? ('0 - height_ext) : height_ext;
                        row_step  <= dir ? A_ONE : '1;
                        dst_row   <= first_dst;
                        dst_ptr   <= first_dst;
                        ready     <= 1'b0;
                        if (width == '0 || height == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= READ;
                            addr_o <= src_base;
                        end
                    end
                end
                READ: begin
                    state <= LATCH;
                end
                LATCH: begin
                    state  <= WRITE;
                    data_o <= data_i;
                    addr_o <= dst_ptr;
                    wr_o   <= 1'b1;
                end
                WRITE: begin
                    wr_o <= 1'b0;
                    if (col_left == '0 && row_left == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= READ;
                        addr_o  <= src_ptr + A_ONE;
                        src_ptr <= src_ptr + A_ONE;
                        if (col_left == '0) begin
                            // next source row: destination moves one column over
                            col_left <= cfg_width - D_ONE;
                            row_left <= row_left - D_ONE;
                            dst_row  <= dst_row + row_step;
                            dst_ptr  <= dst_row + row_step;
                        end else begin
                            col_left <= col_left - D_ONE;
                            dst_ptr  <= dst_ptr + col_step;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rotate90_engine.md
Name: rotate90_engine

Overview:
Pixel-rotation core that sits between the AXI-Lite register block and the image BRAM. It reads a W x H source image of 32-bit pixels from BRAM through a single-port interface with 1-cycle read latency. It writes the image, rotated 90 degrees clockwise or counter-clockwise, to a destination region of the same BRAM. The register block drives the start, geometry and base-address inputs; status (ready/done) feeds back to the register file.

Parameters:
ADDR_WIDTH, 16, BRAM word-address width
DATA_WIDTH, 32, pixel/BRAM word width
DIM_WIDTH, 10, width of the image-dimension inputs (max 1023)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
dir  in  1  0 = clockwise, 1 = counter-clockwise
width  in  DIM_WIDTH  source columns W
height  in  DIM_WIDTH  source rows H
src_base  in  ADDR_WIDTH  word address of source pixel (0,0)
dst_base  in  ADDR_WIDTH  word address of destination pixel (0,0)
ready  out  1  high only in IDLE
done  out  1  one-cycle pulse at end of a job
addr_o  out  ADDR_WIDTH  BRAM address
data_o  out  DATA_WIDTH  BRAM write data
data_i  in  DATA_WIDTH  BRAM read data, valid the cycle after addr_o is presented
wr_o  out  1  BRAM write enable

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=1, done=0, addr_o=0, data_o=0, wr_o=0, all counters and latched config cleared.
- Reset mid-job aborts at once, with no further BRAM accesses; a partially written destination is acceptable.
- On a clock edge in IDLE with start=1: latch dir, width, height, src_base and dst_base; ignore later input changes until the next IDLE.
- start outside IDLE is ignored and not queued.
- FSM states: IDLE, READ, LATCH, WRITE, DONE.
  - IDLE -> READ on start, if W!=0 and H!=0.
  - IDLE -> DONE on start, if W==0 or H==0. No BRAM access occurs in this case.
  - READ: addr_o = src address, wr_o=0. Next state LATCH.
  - LATCH: capture data_i into pixel register, wr_o=0. Next state WRITE.
  - WRITE: addr_o = dst address, data_o = captured pixel, wr_o=1 for exactly this cycle. Next state READ, or DONE after the last pixel.
  - DONE: done=1, ready=0. Next state IDLE.
- Scan order: row-major over the source, r = 0..H-1 (outer), c = 0..W-1 (inner).
- src address = src_base + r*W + c.
- CW dst address = dst_base + c*H + (H-1-r).
- CCW dst address = dst_base + (W-1-c)*H + r.
- All address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- Addresses must be generated incrementally (adders only, no multipliers in the datapath).
- Timing, with the start-sampling edge = cycle 0 and N = W*H:
  - pixel k READ at cycle 3k+1, LATCH at 3k+2, WRITE at 3k+3;
  - done high in cycle 3N+1; ready high again from cycle 3N+2.
- Zero-size job: done high in cycle 1, ready high from cycle 2.
- Overlapping source/destination regions are not detected; results are undefined.
- wr_o is never high outside WRITE, and addr_o holds its value between accesses.

Test Plan:
- 2x3 CW: BRAM[0..5]=10..15, H=2, W=3, src_base=0, dst_base=0x100, dir=0 -> BRAM[0x100..0x105]=13,10,14,11,15,12; done in cycle 19; exactly 6 writes.
- 2x3 CCW: same setup, dir=1 -> BRAM[0x100..0x105]=12,15,11,14,10,13; source region unchanged.
- 1x1 and zero-size cases:
  - W=H=1 -> a single copy src->dst, done in cycle 4;
  - W=0, H=5 -> no wr_o, addr_o stays 0, done in cycle 1, ready back in cycle 2.
- Start while busy: pulse start mid-job with different geometry -> ignored; the original job completes unchanged and exactly one done pulse is produced.
- Address wrap: src_base=0xFFFE, W=4, H=1, dst_base=0x0010, CW -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 and writes 0x0010..0x0013 in order.
- Reset mid-job: assert rst during the WRITE of pixel 2 of a 4x4 job -> wr_o drops asynchronously and ready=1; a new start then produces a correct full 4x4 rotation.
